// File: rtl/screen_ram_loader.sv
// Screen RAM initialiser: streams WORDS words from the screen-init ROM into screen RAM,
// advancing only on cycles where the shared RAM port is granted by the arbiter.
module screen_ram_loader #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8,
   parameter int WORDS  = 2048,
   parameter int BASE   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              grant,
   output logic              req,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_n_cs,
   input  logic [DATA_W-1:0] rom_q,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_we,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [ADDR_W:0]   WordCount = (ADDR_W+1)'(WORDS);
   localparam logic [ADDR_W:0]   LastWord  = (ADDR_W+1)'(WORDS - 1);
   localparam logic [ADDR_W:0]   PtrOne    = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] BaseAddr  = ADDR_W'(BASE);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   rdPtr_q, rdPtr_d;
   logic [ADDR_W:0]   wrPtr_q, wrPtr_d;
   logic              v_q, v_d;
   logic              granted;
   logic              doWrite;
   logic              doRead;

   // A granted RUN cycle both writes the word already sitting in rom_q and fetches the next one.
   assign granted = (state_q == RUN) && grant && !reset;
   assign doWrite = granted && v_q;
   assign doRead  = granted && (rdPtr_q < WordCount);

   assign req      = (state_q == RUN);
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign rom_n_cs = !doRead;
   assign rom_addr = rdPtr_q[ADDR_W-1:0];
   assign ram_we   = doWrite;
   assign ram_addr = BaseAddr + wrPtr_q[ADDR_W-1:0];
   assign ram_data = rom_q;

   always_comb begin
      state_d = state_q;
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      v_d     = v_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               rdPtr_d = '0;
               wrPtr_d = '0;
               v_d     = 1'b0;
            end
         end
         RUN: begin
            if (doWrite) begin
               wrPtr_d = wrPtr_q + PtrOne;
            end
            if (doRead) begin
               rdPtr_d = rdPtr_q + PtrOne;
            end
            // A fresh read always leaves a word pending, even when a write drained the old one.
            if (doRead) begin
               v_d = 1'b1;
            end else if (doWrite) begin
               v_d = 1'b0;
            end
            if (doWrite && (wrPtr_q == LastWord)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         v_q     <= v_d;
      end
   end

endmodule
